serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Two-requester front end for the team's parallel-in/serial-out shifter. It arbitrates round-robin between two parallel word sources and captures the granted word. It then shifts the word out MSB-first on a single serial line with first/last/source framing. An optional inter-word gap and a downstream pause input are supported. It sits between parallel producers and any bit-serial consumer, owning the load/shift sequencing so producers never drive the shifter directly.

## Interface
- WIDTH, 4, serial word width in bits; legal range 2..16
- GAP, 1, idle cycles inserted after each word's last bit; legal range 0..15
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WIDTH  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when valid also high
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WIDTH  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle when valid also high
- tx_en  in  1  downstream enable; low pauses shifting
- sout  out  1  serial data bit
- sout_valid  out  1  sout carries a valid bit this cycle
- sout_first  out  1  current bit is the word MSB
- sout_last  out  1  current bit is the word LSB
- sout_src  out  1  requester index of the word being shifted
- busy  out  1  state is not IDLE

## Operation
- One clock domain; reset is asynchronous and active-low; all state updates on rising clk.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: combinational grant. If exactly one valid is high, that requester wins. If both are high, the requester not served last wins. reqN_ready = (state==IDLE) & grant==N; at most one ready is high per cycle.
- Transfer occurs on valid & ready in the same cycle. The word goes to the shift register, sout_src takes the index, last_served takes the index, bit counter = WIDTH-1, and the next state is SHIFT.
- No transfer in IDLE: stay in IDLE.
- SHIFT: sout = shreg[WIDTH-1]; sout_valid = tx_en; sout_first = tx_en & (cnt==WIDTH-1); sout_last = tx_en & (cnt==0).
- When tx_en=1, shreg shifts left by 1 with 0 in, and cnt decrements. When cnt==0, the next state is GAP if GAP>0, else IDLE.
- When tx_en=0 in SHIFT: shreg, cnt and state hold; no bit is lost or repeated.
- GAP: counts GAP cycles regardless of tx_en, then goes to IDLE. sout_valid, sout_first and sout_last are all 0.
- Outside SHIFT, sout=0, sout_valid=0, sout_first=0 and sout_last=0. sout_src holds its last value.
- busy = (state != IDLE).
- Requesters hold valid and data stable until ready. Dropping valid before ready is permitted and simply withdraws the request. No word is ever accepted without ready.
- tx_en does not gate acceptance in IDLE.
- Counter widths: cnt needs ceil(log2(WIDTH)) bits; the gap counter needs 4 bits.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE; shreg=0, cnt=0, gap counter=0; last_served=1, so req0 wins the first tie. All outputs are 0 immediately. ready becomes combinationally valid again once rst_n is released.
- Reset mid-SHIFT or mid-GAP aborts the word; sout_valid drops in the same cycle rst_n falls. The aborted word is not resent.
- Latency: acceptance in cycle T gives the MSB on sout in cycle T+1, assuming tx_en high.
- With tx_en held high, the LSB appears at T+WIDTH, and the earliest next acceptance is at T+WIDTH+GAP+1.
- Sustained throughput: one word per WIDTH+GAP+1 cycles.
- WIDTH=2, GAP=0: period is 3 cycles, with sout_first and sout_last on consecutive cycles.
- The requester that is not granted keeps its valid high and is guaranteed service on the next IDLE acceptance (starvation-free).

## Test plan
- Single word, WIDTH=4, GAP=1: req0_valid=1, data=4'b1011 at cycle 0.
  - req0_ready=1 at cycle 0.
  - sout=1,0,1,1 with sout_valid=1 in cycles 1-4; first at 1, last at 4, sout_src=0.
  - busy is high in cycles 1-5; IDLE at cycle 6.
- Contention: both valid continuously, req0=4'hA, req1=4'h5.
  - Grants alternate 0,1,0,1, with acceptances at cycles 0,6,12,18.
  - Serial stream is 1010,0101,1010,0101, with sout_src toggling.
- Pause: same as the single-word case with tx_en=0 in cycles 2-3.
  - sout_valid is low in cycles 2-3 and sout stays 0-bit-held.
  - Bits 1,0,1,1 appear in cycles 1,4,5,6; last at 6; acceptance is possible again at cycle 8.
- Late request: req1_valid rises at cycle 3 while req0's word is shifting.
  - req1_ready stays 0 until IDLE at cycle 6, then the transfer occurs at cycle 6.
- Reset mid-word: assert rst_n=0 during cycle 2 of a shift.
  - All outputs are 0 immediately.
  - After release, a tie grants req0 first.
- GAP=0, WIDTH=2, req0 streaming 2'b10: acceptances at cycles 0,3,6; sout pattern 1,0,(idle),1,0.

Source files
------------

// File: rtl/serial_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter_if
// Brief    : Requester/serial-line bundle between producers, arbiter and sink.
// Revision : 1.0
// ============================================================================
interface serial_tx_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             tx_en;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             sout_src;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_en,
        input  req0_ready, req1_ready, sout, sout_valid, sout_first,
               sout_last, sout_src, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_en,
        output req0_ready, req1_ready, sout, sout_valid, sout_first,
               sout_last, sout_src, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Brief    : Round-robin two-source word arbiter feeding an MSB-first shifter.
// Revision : 1.0
// ============================================================================
module serial_tx_arbiter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  wire              clk,
    input  wire              rst_n,
    serial_tx_arbiter_if.slave bus
);

    localparam int               c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_CNT_TOP  = c_CW'(WIDTH - 1);
    localparam logic [3:0]       c_GAP_TOP  = 4'((GAP > 0) ? (GAP - 1) : 0);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [c_CW-1:0]  r_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_last_served;
    logic             r_src;

    logic w_idle;
    logic w_shift;
    logic w_rdy0;
    logic w_rdy1;

    assign w_idle  = (r_state == c_ST_IDLE);
    assign w_shift = (r_state == c_ST_SHIFT);

    // A tie goes to whichever requester was not served last; ready is held
    // low while rst_n is asserted so every output reads 0 during reset.
    assign w_rdy0 = rst_n & w_idle & bus.req0_valid & (~bus.req1_valid |  r_last_served);
    assign w_rdy1 = rst_n & w_idle & bus.req1_valid & (~bus.req0_valid | ~r_last_served);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_shreg       <= '0;
            r_cnt         <= '0;
            r_gap_cnt     <= '0;
            r_last_served <= 1'b1;
            r_src         <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rdy0 | w_rdy1) begin
                        r_shreg       <= w_rdy1 ? bus.req1_data : bus.req0_data;
                        r_src         <= w_rdy1;
                        r_last_served <= w_rdy1;
                        r_cnt         <= c_CNT_TOP;
                        r_state       <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    // A low tx_en freezes the word in place so no bit is lost.
                    if (bus.tx_en) begin
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_cnt   <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            if (GAP > 0) begin
                                r_state   <= c_ST_GAP;
                                r_gap_cnt <= c_GAP_TOP;
                            end else begin
                                r_state   <= c_ST_IDLE;
                            end
                        end
                    end
                end
                c_ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.sout       = w_shift & r_shreg[WIDTH-1];
    assign bus.sout_valid = w_shift & bus.tx_en;
    assign bus.sout_first = w_shift & bus.tx_en & (r_cnt == c_CNT_TOP);
    assign bus.sout_last  = w_shift & bus.tx_en & (r_cnt == '0);
    assign bus.sout_src   = r_src;
    assign bus.busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_arbiter
// Brief    : Directed and random checks of two arbiter configurations.
// Revision : 1.0
// ============================================================================
module tb_serial_tx_arbiter;

    localparam int c_WA = 4;
    localparam int c_GA = 1;
    localparam int c_WB = 2;
    localparam int c_GB = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  v0, v1, ten, rep0, rep1;
    logic [15:0] d0 [2];
    logic [15:0] d1 [2];
    logic [1:0]  o_rdy0, o_rdy1, o_sout, o_sv, o_sf, o_sl, o_src, o_busy;

    serial_tx_arbiter_if #(.WIDTH(c_WA)) ifa ();
    serial_tx_arbiter_if #(.WIDTH(c_WB)) ifb ();

    serial_tx_arbiter #(.WIDTH(c_WA), .GAP(c_GA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    serial_tx_arbiter #(.WIDTH(c_WB), .GAP(c_GB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifa.req0_valid = v0[0];
    assign ifa.req1_valid = v1[0];
    assign ifa.req0_data  = d0[0][c_WA-1:0];
    assign ifa.req1_data  = d1[0][c_WA-1:0];
    assign ifa.tx_en      = ten[0];
    assign ifb.req0_valid = v0[1];
    assign ifb.req1_valid = v1[1];
    assign ifb.req0_data  = d0[1][c_WB-1:0];
    assign ifb.req1_data  = d1[1][c_WB-1:0];
    assign ifb.tx_en      = ten[1];

    assign o_rdy0 = {ifb.req0_ready, ifa.req0_ready};
    assign o_rdy1 = {ifb.req1_ready, ifa.req1_ready};
    assign o_sout = {ifb.sout,       ifa.sout};
    assign o_sv   = {ifb.sout_valid, ifa.sout_valid};
    assign o_sf   = {ifb.sout_first, ifa.sout_first};
    assign o_sl   = {ifb.sout_last,  ifa.sout_last};
    assign o_src  = {ifb.sout_src,   ifa.sout_src};
    assign o_busy = {ifb.busy,       ifa.busy};

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int dk = 0;
    bit rnd = 1'b0;

    // Reference: a word in flight is tracked as "bits still to send" plus
    // "gap cycles still to wait"; the device is idle when both are zero.
    int          m_left [2];
    int          m_gap  [2];
    logic        m_last [2];
    logic        m_src  [2];
    logic [15:0] m_word [2];
    logic [1:0]  acc0, acc1;

    int acc_c[$];
    int acc_s[$];

    function automatic int w_of(input int k);
        return (k == 0) ? c_WA : c_WB;
    endfunction

    function automatic int g_of(input int k);
        return (k == 0) ? c_GA : c_GB;
    endfunction

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    endtask

    task automatic model_step(input int k);
        logic idle, e_r0, e_r1, e_sout, e_sv, e_sf, e_sl, e_src, e_busy, sh;
        idle   = (m_left[k] == 0) && (m_gap[k] == 0);
        sh     = (m_left[k] > 0);
        e_r0 = 1'b0; e_r1 = 1'b0; e_sout = 1'b0; e_sv = 1'b0;
        e_sf = 1'b0; e_sl = 1'b0; e_src = 1'b0; e_busy = 1'b0;
        if (rst_n) begin
            e_r0   = idle && v0[k] && (!v1[k] || m_last[k]);
            e_r1   = idle && v1[k] && (!v0[k] || !m_last[k]);
            e_sout = sh ? m_word[k][m_left[k]-1] : 1'b0;
            e_sv   = sh && ten[k];
            e_sf   = e_sv && (m_left[k] == w_of(k));
            e_sl   = e_sv && (m_left[k] == 1);
            e_src  = m_src[k];
            e_busy = !idle;
        end
        chk("req0_ready", k, 16'(o_rdy0[k]), 16'(e_r0));
        chk("req1_ready", k, 16'(o_rdy1[k]), 16'(e_r1));
        chk("sout",       k, 16'(o_sout[k]), 16'(e_sout));
        chk("sout_valid", k, 16'(o_sv[k]),   16'(e_sv));
        chk("sout_first", k, 16'(o_sf[k]),   16'(e_sf));
        chk("sout_last",  k, 16'(o_sl[k]),   16'(e_sl));
        chk("sout_src",   k, 16'(o_src[k]),  16'(e_src));
        chk("busy",       k, 16'(o_busy[k]), 16'(e_busy));
        if (k == dk && v0[k] && o_rdy0[k]) begin acc_c.push_back(cyc); acc_s.push_back(0); end
        if (k == dk && v1[k] && o_rdy1[k]) begin acc_c.push_back(cyc); acc_s.push_back(1); end
        acc0[k] = e_r0;
        acc1[k] = e_r1;
        if (!rst_n) begin
            m_left[k] = 0; m_gap[k] = 0; m_last[k] = 1'b1; m_src[k] = 1'b0;
        end else if (idle) begin
            if (e_r0 || e_r1) begin
                m_word[k] = e_r1 ? d1[k] : d0[k];
                m_src[k]  = e_r1;
                m_last[k] = e_r1;
                m_left[k] = w_of(k);
            end
        end else if (sh) begin
            if (ten[k]) begin
                m_left[k]--;
                if (m_left[k] == 0) m_gap[k] = g_of(k);
            end
        end else begin
            m_gap[k]--;
        end
    endtask

    task automatic update_inputs();
        for (int k = 0; k < 2; k++) begin
            if (acc0[k]) v0[k] = rep0[k];
            if (acc1[k]) v1[k] = rep1[k];
            if (rnd) begin
                if (v0[k] && !acc0[k] && $urandom_range(0, 15) == 0) v0[k] = 1'b0;
                else if (!v0[k] && $urandom_range(0, 2) == 0) begin v0[k] = 1'b1; d0[k] = 16'($urandom); end
                if (v1[k] && !acc1[k] && $urandom_range(0, 15) == 0) v1[k] = 1'b0;
                else if (!v1[k] && $urandom_range(0, 2) == 0) begin v1[k] = 1'b1; d1[k] = 16'($urandom); end
                ten[k] = ($urandom_range(0, 3) != 0);
            end
        end
        if (rnd) rst_n = ($urandom_range(0, 199) != 0);
    endtask

    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        update_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_scn(input int k);
        v0 = '0; v1 = '0; rep0 = '0; rep1 = '0; ten = '1;
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        dk = k;
        cyc = 0;
        acc_c.delete();
        acc_s.delete();
    endtask

    task automatic chk_acc(input string tag, input int n, input int c[4], input int s[4]);
        chk({tag, "_count"}, dk, 16'(acc_c.size()), 16'(n));
        for (int i = 0; i < n && i < acc_c.size(); i++) begin
            chk({tag, "_cycle"}, dk, 16'(acc_c[i]), 16'(c[i]));
            chk({tag, "_src"},   dk, 16'(acc_s[i]), 16'(s[i]));
        end
    endtask

    initial begin
        v0 = '0; v1 = '0; rep0 = '0; rep1 = '0; ten = '1;
        for (int k = 0; k < 2; k++) begin
            d0[k] = '0; d1[k] = '0; m_word[k] = '0;
            m_left[k] = 0; m_gap[k] = 0; m_last[k] = 1'b1; m_src[k] = 1'b0;
        end
        acc0 = '0; acc1 = '0;
        #2 rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;

        // Single word 1011 on requester 0.
        start_scn(0);
        v0[0] = 1'b1; d0[0] = 16'hB;
        run(8);
        chk_acc("single", 1, '{0, 0, 0, 0}, '{0, 0, 0, 0});

        // Both requesters streaming: grants alternate every 6 cycles.
        start_scn(0);
        v0[0] = 1'b1; v1[0] = 1'b1; rep0[0] = 1'b1; rep1[0] = 1'b1;
        d0[0] = 16'hA; d1[0] = 16'h5;
        run(24);
        chk_acc("contend", 4, '{0, 6, 12, 18}, '{0, 1, 0, 1});

        // Downstream pause for two cycles stretches the word by two.
        start_scn(0);
        v0[0] = 1'b1; rep0[0] = 1'b1; d0[0] = 16'hB;
        run(2);
        ten[0] = 1'b0;
        run(2);
        ten[0] = 1'b1;
        run(6);
        chk_acc("pause", 2, '{0, 8, 0, 0}, '{0, 0, 0, 0});

        // Requester 1 arrives mid-word and waits for IDLE.
        start_scn(0);
        v0[0] = 1'b1; d0[0] = 16'h6;
        run(3);
        v1[0] = 1'b1; d1[0] = 16'h9;
        run(5);
        chk_acc("late", 2, '{0, 6, 0, 0}, '{0, 1, 0, 0});

        // Reset in the middle of a word, then a tie goes to requester 0.
        start_scn(0);
        v0[0] = 1'b1; d0[0] = 16'hF;
        run(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        acc_c.delete(); acc_s.delete();
        v0[0] = 1'b1; v1[0] = 1'b1; d0[0] = 16'h3; d1[0] = 16'hC;
        run(10);
        chk_acc("rst_mid", 2, '{3, 9, 0, 0}, '{0, 1, 0, 0});

        // Narrow configuration without a gap: one word every 3 cycles.
        start_scn(1);
        v0[1] = 1'b1; rep0[1] = 1'b1; d0[1] = 16'h2;
        run(9);
        chk_acc("narrow", 3, '{0, 3, 6, 0}, '{0, 0, 0, 0});

        // Random traffic on both configurations.
        start_scn(2);
        rnd = 1'b1;
        run(2000);
        rnd = 1'b0;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
